// File: rtl/ntt_pkg.sv
// ----------------------------------------------------------------------------
// ntt_pkg
//   Shared definitions for the NTT twiddle-factor generator:
//   - default coefficient width, table depth, modulus and roots of unity
//   - FSM state encoding for twiddle_gen
//   - reverse_bits(): bit-reversal of the low nbits of a value
// ----------------------------------------------------------------------------
package ntt_pkg;

    // Defaults: Q = 17 is prime and 17 = 1 mod 16, so a primitive 16th root
    // of unity exists; 3 is one, and 3 * 6 = 18 = 1 mod 17.
    localparam int DEF_W       = 17;
    localparam int DEF_LOG_N   = 3;
    localparam int DEF_Q       = 17;
    localparam int DEF_PSI     = 3;
    localparam int DEF_PSI_INV = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GEN  = 2'd1,
        ST_OUT  = 2'd2
    } state_e;

    // Reverse the order of the low nbits of value; upper bits return as zero.
    function automatic logic [31:0] reverse_bits(input logic [31:0] value,
                                                 input int          nbits);
        logic [31:0] result;
        result = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < nbits) begin
                result[i] = value[nbits - 1 - i];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/twiddle_modmul.sv
// ----------------------------------------------------------------------------
// twiddle_modmul
//   Combinational modular multiplier: r = (a * b) mod Q.
//   The full 2W-bit product is formed and reduced exactly, so r < Q for any
//   operands.
//
// Ports
//   a  input  [W-1:0]  multiplicand
//   b  input  [W-1:0]  multiplier
//   r  output [W-1:0]  (a * b) mod Q
// ----------------------------------------------------------------------------
module twiddle_modmul
    import ntt_pkg::*;
#(
    parameter int W = DEF_W,
    parameter int Q = DEF_Q
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] r
);

    localparam logic [2*W-1:0] Q_WIDE = (2*W)'(Q);

    logic [2*W-1:0] prod;

    // Zero-extend both operands first so the multiply is evaluated at 2W bits.
    assign prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    assign r    = W'(prod % Q_WIDE);

endmodule

// File: rtl/twiddle_gen.sv
// ----------------------------------------------------------------------------
// twiddle_gen
//   Builds a table of N = 2**LOG_N twiddle factors psi^k mod Q (or powers of
//   psi^-1) and streams it out over a valid/ready handshake, in natural or
//   bit-reversed index order. A built table is cached: a request with the
//   same direction as the stored table skips regeneration.
//
// Ports
//   clk       input            rising-edge clock
//   rst_n     input            synchronous active-low reset
//   start     input            one-cycle request for a full stream (IDLE only)
//   inv       input            0: powers of PSI, 1: powers of PSI_INV
//   bitrev    input            1: emit entries in bit-reversed index order
//   tw_data   output [W-1:0]   twiddle value psi^tw_idx mod Q
//   tw_idx    output [LOG_N-1:0] exponent of tw_data
//   tw_valid  output           tw_data/tw_idx/tw_last are valid
//   tw_ready  input            consumer takes the beat when valid && ready
//   tw_last   output           final (Nth) beat of the stream
//   busy      output           FSM is not in IDLE
//   done      output           one-cycle pulse after the last beat is taken
// ----------------------------------------------------------------------------
module twiddle_gen
    import ntt_pkg::*;
#(
    parameter int W       = DEF_W,
    parameter int LOG_N   = DEF_LOG_N,
    parameter int Q       = DEF_Q,
    parameter int PSI     = DEF_PSI,
    parameter int PSI_INV = DEF_PSI_INV
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             inv,
    input  logic             bitrev,
    output logic [W-1:0]     tw_data,
    output logic [LOG_N-1:0] tw_idx,
    output logic             tw_valid,
    input  logic             tw_ready,
    output logic             tw_last,
    output logic             busy,
    output logic             done
);

    localparam int               N        = 1 << LOG_N;
    localparam logic [LOG_N-1:0] LAST_IDX = LOG_N'(N - 1);
    localparam logic [LOG_N-1:0] IDX_ONE  = LOG_N'(1);
    localparam logic [W-1:0]     ACC_ONE  = W'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e           state_q,       state_d;
    logic [LOG_N-1:0] k_q,           k_d;
    logic [LOG_N-1:0] j_q,           j_d;
    logic [W-1:0]     acc_q,         acc_d;
    logic             inv_q,         inv_d;
    logic             bitrev_q,      bitrev_d;
    logic             table_valid_q, table_valid_d;
    logic             table_inv_q,   table_inv_d;
    logic [W-1:0]     tw_data_q,     tw_data_d;
    logic [LOG_N-1:0] tw_idx_q,      tw_idx_d;
    logic             tw_valid_q,    tw_valid_d;
    logic             tw_last_q,     tw_last_d;
    logic             busy_q,        busy_d;
    logic             done_q,        done_d;

    logic [W-1:0]     mem_q [N];
    logic             mem_we;
    logic [LOG_N-1:0] mem_waddr;
    logic [W-1:0]     mem_wdata;

    logic [W-1:0]     root;
    logic [W-1:0]     acc_next;
    logic             load_en;
    logic [LOG_N-1:0] load_j;
    logic [LOG_N-1:0] load_idx;

    // Stream position j maps to a table index, optionally bit-reversed.
    function automatic logic [LOG_N-1:0] map_idx(input logic [LOG_N-1:0] j,
                                                 input logic             br);
        return br ? LOG_N'(reverse_bits(32'(j), LOG_N)) : j;
    endfunction

    assign root = inv_q ? W'(PSI_INV) : W'(PSI);

    twiddle_modmul #(
        .W (W),
        .Q (Q)
    ) u_modmul (
        .a (acc_q),
        .b (root),
        .r (acc_next)
    );

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal assigned below gets a default here first, so no
        // path through the case leaves it unassigned and no latch is inferred.
        state_d       = state_q;
        k_d           = k_q;
        j_d           = j_q;
        acc_d         = acc_q;
        inv_d         = inv_q;
        bitrev_d      = bitrev_q;
        table_valid_d = table_valid_q;
        table_inv_d   = table_inv_q;
        tw_data_d     = tw_data_q;
        tw_idx_d      = tw_idx_q;
        tw_valid_d    = tw_valid_q;
        tw_last_d     = tw_last_q;
        done_d        = 1'b0;
        mem_we        = 1'b0;
        mem_waddr     = k_q;
        mem_wdata     = acc_q;
        load_en       = 1'b0;
        load_j        = j_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    inv_d    = inv;
                    bitrev_d = bitrev;
                    k_d      = '0;
                    j_d      = '0;
                    acc_d    = ACC_ONE;
                    if (table_valid_q && (table_inv_q == inv)) begin
                        state_d = ST_OUT;
                    end else begin
                        // The table is about to be overwritten; it must not be
                        // reused unless this build completes.
                        table_valid_d = 1'b0;
                        state_d       = ST_GEN;
                    end
                end
            end

            ST_GEN: begin
                mem_we = 1'b0 == 1'b0;
                acc_d  = acc_next;
                k_d    = k_q + IDX_ONE;
                if (k_q == LAST_IDX) begin
                    k_d           = '0;
                    acc_d         = ACC_ONE;
                    table_valid_d = 1'b1;
                    table_inv_d   = inv_q;
                    state_d       = ST_OUT;
                    // Beat 0 always reads index 0, which was written on the
                    // first GEN cycle, so it is presented together with the
                    // move to OUT rather than one cycle later.
                    load_en       = 1'b1;
                    load_j        = '0;
                end
            end

            ST_OUT: begin
                if (!tw_valid_q) begin
                    load_en = 1'b1;
                    load_j  = j_q;
                end else if (tw_ready) begin
                    if (tw_last_q) begin
                        tw_valid_d = 1'b0;
                        tw_last_d  = 1'b0;
                        done_d     = 1'b1;
                        j_d        = '0;
                        state_d    = ST_IDLE;
                    end else begin
                        // Load the next beat on the accepting edge so a
                        // consumer holding ready high sees no gaps.
                        j_d     = j_q + IDX_ONE;
                        load_en = 1'b1;
                        load_j  = j_q + IDX_ONE;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase

        load_idx = map_idx(load_j, bitrev_q);
        if (load_en) begin
            tw_data_d  = mem_q[load_idx];
            tw_idx_d   = load_idx;
            tw_valid_d = 1'b1;
            tw_last_d  = (load_j == LAST_IDX);
        end

        busy_d = (state_d != ST_IDLE);
    end

    // ------------------------------------------------------------------
    // Control and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state is updated with non-blocking assignments so
        // every flop samples the pre-edge values regardless of statement order.
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            k_q           <= '0;
            j_q           <= '0;
            acc_q         <= ACC_ONE;
            inv_q         <= 1'b0;
            bitrev_q      <= 1'b0;
            table_valid_q <= 1'b0;
            table_inv_q   <= 1'b0;
            tw_data_q     <= '0;
            tw_idx_q      <= '0;
            tw_valid_q    <= 1'b0;
            tw_last_q     <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            k_q           <= k_d;
            j_q           <= j_d;
            acc_q         <= acc_d;
            inv_q         <= inv_d;
            bitrev_q      <= bitrev_d;
            table_valid_q <= table_valid_d;
            table_inv_q   <= table_inv_d;
            tw_data_q     <= tw_data_d;
            tw_idx_q      <= tw_idx_d;
            tw_valid_q    <= tw_valid_d;
            tw_last_q     <= tw_last_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    // ------------------------------------------------------------------
    // Twiddle table: one write port (GEN), one read port (OUT)
    // ------------------------------------------------------------------
    // NOTE: the table has no reset; its contents are only trusted while
    // table_valid_q is set, which keeps it a plain register file.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign tw_data  = tw_data_q;
    assign tw_idx   = tw_idx_q;
    assign tw_valid = tw_valid_q;
    assign tw_last  = tw_last_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_twiddle_gen.sv
// ----------------------------------------------------------------------------
// tb_twiddle_gen
//   Directed bench for twiddle_gen at the defaults Q=17, N=8, PSI=3,
//   PSI_INV=6. Expected tables are hand-computed powers mod 17.
// ----------------------------------------------------------------------------
module tb_twiddle_gen;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        start    = 1'b0;
    logic        inv      = 1'b0;
    logic        bitrev   = 1'b0;
    logic        tw_ready = 1'b0;
    logic [16:0] tw_data;
    logic [2:0]  tw_idx;
    logic        tw_valid;
    logic        tw_last;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;

    // Powers of 3 mod 17, index 0 in the low slot.
    localparam logic [7:0][16:0] PSI_FWD = {17'd11, 17'd15, 17'd5, 17'd13,
                                            17'd10, 17'd9,  17'd3, 17'd1};
    // Powers of 6 mod 17.
    localparam logic [7:0][16:0] INV_FWD = {17'd14, 17'd8, 17'd7, 17'd4,
                                            17'd12, 17'd2, 17'd6, 17'd1};
    // Powers of 6 read in bit-reversed order 0,4,2,6,1,5,3,7.
    localparam logic [7:0][16:0] INV_BR  = {17'd14, 17'd12, 17'd7, 17'd6,
                                            17'd8,  17'd2,  17'd4, 17'd1};
    localparam logic [7:0][2:0]  IDX_LIN = {3'd7, 3'd6, 3'd5, 3'd4,
                                            3'd3, 3'd2, 3'd1, 3'd0};
    localparam logic [7:0][2:0]  IDX_BR  = {3'd7, 3'd3, 3'd5, 3'd1,
                                            3'd6, 3'd2, 3'd4, 3'd0};

    always #5 clk = ~clk;

    twiddle_gen dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .inv      (inv),
        .bitrev   (bitrev),
        .tw_data  (tw_data),
        .tw_idx   (tw_idx),
        .tw_valid (tw_valid),
        .tw_ready (tw_ready),
        .tw_last  (tw_last),
        .busy     (busy),
        .done     (done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " tw_data"},  32'(tw_data),  32'd0);
        check({tag, " tw_idx"},   32'(tw_idx),   32'd0);
        check({tag, " tw_valid"}, 32'(tw_valid), 32'd0);
        check({tag, " tw_last"},  32'(tw_last),  32'd0);
        check({tag, " busy"},     32'(busy),     32'd0);
        check({tag, " done"},     32'(done),     32'd0);
    endtask

    // Request one stream and check latency, every presented beat (including
    // stalled repeats), tw_last, and the closing done pulse. With poke set,
    // start is also pulsed mid-stream and on the final accepting cycle.
    task automatic run_stream(input string            name,
                              input logic             i_inv,
                              input logic             i_br,
                              input int               exp_lat,
                              input logic [7:0][16:0] ed,
                              input logic [7:0][2:0]  ei,
                              input logic [15:0]      rpat,
                              input bit               poke);
        int lat;
        int beats;
        int cyc;
        start    = 1'b1;
        inv      = i_inv;
        bitrev   = i_br;
        tw_ready = rpat[0];
        tick();
        start = 1'b0;
        lat   = 1;
        check({name, " busy"}, 32'(busy), 32'd1);
        while (!tw_valid && lat < 40) begin
            check({name, " no early done"}, 32'(done), 32'd0);
            tick();
            lat++;
        end
        check({name, " latency"}, 32'(lat), 32'(exp_lat));

        beats = 0;
        cyc   = 0;
        while (beats < 8 && cyc < 200) begin
            tw_ready = rpat[cyc % 16];
            if (poke && beats == 3) begin
                start = 1'b1;
                inv   = ~i_inv;
            end
            check($sformatf("%s beat%0d valid", name, beats), 32'(tw_valid), 32'd1);
            check($sformatf("%s beat%0d data", name, beats), 32'(tw_data), 32'(ed[beats]));
            check($sformatf("%s beat%0d idx", name, beats), 32'(tw_idx), 32'(ei[beats]));
            check($sformatf("%s beat%0d last", name, beats), 32'(tw_last), 32'(beats == 7));
            check($sformatf("%s beat%0d done", name, beats), 32'(done), 32'd0);
            if (tw_ready) begin
                beats++;
                if (poke && beats == 8) begin
                    start = 1'b1;
                    inv   = ~i_inv;
                end
            end
            tick();
            start = 1'b0;
            cyc++;
        end
        check({name, " beat count"}, 32'(beats), 32'd8);
        check({name, " done pulse"}, 32'(done), 32'd1);
        check({name, " valid drop"}, 32'(tw_valid), 32'd0);
        check({name, " idle busy"}, 32'(busy), 32'd0);
        tw_ready = 1'b0;
        tick();
        check({name, " done one cycle"}, 32'(done), 32'd0);
        check({name, " stays idle"}, 32'(busy), 32'd0);
        check({name, " no new stream"}, 32'(tw_valid), 32'd0);
    endtask

    initial begin
        // Reset
        rst_n = 1'b0;
        tick();
        tick();
        check_idle_outputs("reset");
        rst_n = 1'b1;
        tick();
        check_idle_outputs("post reset");

        // Fresh forward table, natural order, ready held high
        run_stream("fwd", 1'b0, 1'b0, 9, PSI_FWD, IDX_LIN, 16'hFFFF, 1'b0);
        // Inverse direction forces a rebuild
        run_stream("inv", 1'b1, 1'b0, 9, INV_FWD, IDX_LIN, 16'hFFFF, 1'b0);
        // Same direction, bit-reversed: served from the cached table
        run_stream("inv_br", 1'b1, 1'b1, 2, INV_BR, IDX_BR, 16'hFFFF, 1'b0);
        // Ready pattern 1,0,0,1 with ignored start pulses during OUT
        run_stream("stall", 1'b1, 1'b0, 2, INV_FWD, IDX_LIN, 16'h9999, 1'b1);

        // Abort a rebuild with reset when k = 4
        start  = 1'b1;
        inv    = 1'b0;
        bitrev = 1'b0;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("abort gen busy", 32'(busy), 32'd1);
            check("abort gen done", 32'(done), 32'd0);
            tick();
        end
        rst_n = 1'b0;
        tick();
        check_idle_outputs("abort reset");
        rst_n = 1'b1;
        tick();
        check_idle_outputs("abort release");

        // Full rebuild after the aborted run
        run_stream("rerun", 1'b0, 1'b0, 9, PSI_FWD, IDX_LIN, 16'hFFFF, 1'b0);

        // Reset in IDLE invalidates a complete matching table
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        run_stream("post_rst", 1'b0, 1'b0, 9, PSI_FWD, IDX_LIN, 16'hFFFF, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/twiddle_gen.md
TWIDDLE_GEN -- requirements
Module: twiddle_gen

Interface
REQ-001 Parameter W, default 17: coefficient width in bits.
REQ-002 Parameter LOG_N, default 3: log2 of table depth; N = 2**LOG_N.
REQ-003 Parameter Q, default 17: prime modulus; Q < 2**W and Q ≡ 1 mod 2N.
REQ-004 Parameter PSI, default 3: primitive 2N-th root of unity mod Q.
REQ-005 Parameter PSI_INV, default 6: PSI^-1 mod Q.
REQ-006 clk  input  1  single clock; all state updates on its rising edge.
REQ-007 rst_n  input  1  synchronous, active-low reset.
REQ-008 start  input  1  one-cycle request for one full table stream.
REQ-009 inv  input  1  0 = powers of PSI, 1 = powers of PSI_INV; sampled with start.
REQ-010 bitrev  input  1  1 = emit in bit-reversed index order; sampled with start.
REQ-011 tw_data  output  W  twiddle value psi^idx mod Q.
REQ-012 tw_idx  output  LOG_N  exponent of tw_data.
REQ-013 tw_valid  output  1  tw_data/tw_idx/tw_last are valid.
REQ-014 tw_ready  input  1  consumer accepts the beat when tw_valid && tw_ready.
REQ-015 tw_last  output  1  marks the Nth beat of a stream.
REQ-016 busy  output  1  high in any state other than IDLE.
REQ-017 done  output  1  one-cycle pulse on the cycle after the last beat is accepted.

Function
REQ-018 FSM states IDLE, GEN, OUT; start is honoured only in IDLE and ignored otherwise.
REQ-019 IDLE + start: latch inv and bitrev; go to GEN unless the table is valid and was built with the same inv, in which case go straight to OUT.
REQ-020 GEN: counter k runs 0..N-1, one entry per cycle; mem[k] = acc; acc starts at 1 and updates as acc = acc*root mod Q; root = latched inv ? PSI_INV : PSI.
REQ-021 After k = N-1 is written, set table_valid, record table_inv = inv, go to OUT; GEN lasts exactly N cycles.
REQ-022 Product width is 2W; reduction is exact, so every stored value is < Q.
REQ-023 OUT: read counter j runs 0..N-1; idx = bitrev ? reverse(j) over LOG_N bits : j; tw_data = mem[idx], tw_idx = idx; outputs are registered.
REQ-024 tw_valid rises 1 cycle after entering OUT; j advances only on an accepted beat; while tw_valid && !tw_ready all outputs hold stable.
REQ-025 Fresh table latency: start at cycle t gives first tw_valid at t+N+1; cached table gives first tw_valid at t+2.
REQ-026 tw_last = 1 only with the beat where j = N-1; on its acceptance tw_valid drops, done pulses next cycle, state returns to IDLE.
REQ-027 With tw_ready held high, the stream is N consecutive beats with no gaps.
REQ-028 A start in the same cycle as the final acceptance is ignored.
REQ-029 Wrap-around: LOG_N-bit counters never wrap within a stream; terminal count is decoded at N-1.

Reset
REQ-030 When rst_n = 0 at a clock edge: state IDLE; k, j, acc cleared (acc = 1); table_valid = 0; table_inv = 0.
REQ-031 Output reset values: tw_data 0, tw_idx 0, tw_valid 0, tw_last 0, busy 0, done 0.
REQ-032 Reset during GEN or OUT aborts the stream with no done pulse; the next start rebuilds the table.
REQ-033 mem contents are not reset; table_valid alone gates reuse.

Structure
REQ-034 Package ntt_pkg holds the state enum, the reverse-bits function, and the default W, LOG_N, Q, PSI and PSI_INV constants.
REQ-035 Sub-module twiddle_modmul: combinational, computes (a*b) mod Q with W-bit operands and a W-bit result; twiddle_gen instantiates it once.
REQ-036 mem is an N x W register array with one write port (GEN) and one read port (OUT).

Verification (defaults: Q=17, N=8, PSI=3)
REQ-037 start, inv=0, bitrev=0, ready=1 -> tw_data 1,3,9,10,13,5,15,11, idx 0..7, first valid at t+9, tw_last on beat 8, done next cycle.
REQ-038 start, inv=1, bitrev=0 -> 1,6,2,12,4,7,8,14; GEN re-run, first valid at t+9.
REQ-039 Repeat inv=1 with bitrev=1 -> idx 0,4,2,6,1,5,3,7 with data 1,4,2,8,6,7,12,14; cached, first valid at t+2.
REQ-040 tw_ready toggled 1,0,0,1,... -> data and idx held stable while stalled; exactly 8 accepted beats, sequence unchanged.
REQ-041 start pulsed during OUT -> ignored; rst_n low during GEN at k=4, then start inv=0 -> full GEN rerun, correct sequence, no done from the aborted run.
